// File: rtl/dma_pkg.sv
// Shared types for the DMA descriptor path: descriptor payload, transfer kinds, arbiter states.
package dma_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned BYTES_W = 32;
    localparam int unsigned XTYPE_W = 2;

    localparam logic [XTYPE_W-1:0] XFER_M2M = 2'd0;
    localparam logic [XTYPE_W-1:0] XFER_M2D = 2'd1;
    localparam logic [XTYPE_W-1:0] XFER_D2M = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0]  src_addr;
        logic [ADDR_W-1:0]  dst_addr;
        logic [BYTES_W-1:0] bytes;
        logic [XTYPE_W-1:0] xfer_type;
    } dma_desc_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dma_desc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module dma_desc_arbiter_rr_pick #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt_onehot_c,
    output logic [IDX_W-1:0]  gnt_idx_c,
    output logic              gnt_any_c
);

    // Scan NUM_CH candidates starting at ptr; the first requester wins.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        gnt_onehot_c = '0;
        gnt_idx_c    = '0;
        gnt_any_c    = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = IDX_W'(cand);
            if (!gnt_any_c && req[cand_idx]) begin
                gnt_any_c              = 1'b1;
                gnt_onehot_c[cand_idx] = 1'b1;
                gnt_idx_c              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dma_desc_arbiter.sv
// Round-robin descriptor scheduler feeding one DMA engine, one descriptor in flight.
// Optional transfer watchdog: define DMA_ARB_WDOG_EN.
module dma_desc_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WDOG_CYCLES = 65536,
    localparam int unsigned IDX_W      = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [NUM_CH-1:0]     ch_valid,
    output logic [NUM_CH-1:0]     ch_ready,
    input  dma_desc_t             ch_desc [NUM_CH],
    output logic [NUM_CH-1:0]     ch_done,
    output logic [NUM_CH-1:0]     ch_err,
    output logic                  eng_desc_valid,
    input  logic                  eng_desc_ready,
    output dma_desc_t             eng_desc,
    input  logic                  eng_xfer_done,
    input  logic                  eng_xfer_error,
    output logic                  arb_idle,
    output logic [IDX_W-1:0]      cur_ch,
    output logic                  wdog_trip
);

    if (NUM_CH < 2 || NUM_CH > 16 || WDOG_CYCLES < 2) begin : g_cfg_check
        $error("dma_desc_arbiter: NUM_CH must be 2..16 and WDOG_CYCLES >= 2");
    end

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    cur_ch_q, cur_ch_d;
    dma_desc_t           desc_q, desc_d;
    logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
    logic [NUM_CH-1:0]   ch_err_q, ch_err_d;
    logic                eng_valid_q, eng_valid_d;
    logic                idle_q, idle_d;
    logic                wdog_trip_q, wdog_trip_d;

    logic [NUM_CH-1:0]   pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

`ifdef DMA_ARB_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
`endif

    dma_desc_arbiter_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req          (ch_valid & ch_en),
        .ptr          (rr_ptr_q),
        .gnt_onehot_c (pick_onehot),
        .gnt_idx_c    (pick_idx),
        .gnt_any_c    (pick_any)
    );

    // Next-state, descriptor capture, completion routing and watchdog counting.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_ch_d    = cur_ch_q;
        desc_d      = desc_q;
        ch_done_d   = '0;
        ch_err_d    = '0;
        wdog_trip_d = 1'b0;
        ch_ready    = '0;
`ifdef DMA_ARB_WDOG_EN
        wdog_cnt_d  = wdog_cnt_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    ch_ready = pick_onehot;
                    desc_d   = ch_desc[pick_idx];
                    cur_ch_d = pick_idx;
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + IDX_W'(1);
                    if (ch_desc[pick_idx].bytes == '0) begin
                        // Nothing to move: complete OK without touching the engine.
                        state_d             = ARB_RESP;
                        ch_done_d[pick_idx] = 1'b1;
                    end else begin
                        state_d = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                if (eng_desc_ready) begin
                    state_d = ARB_WAIT;
`ifdef DMA_ARB_WDOG_EN
                    wdog_cnt_d = '0;
`endif
                end
            end
            ARB_WAIT: begin
                if (eng_xfer_error) begin
                    state_d             = ARB_RESP;
                    ch_done_d[cur_ch_q] = 1'b1;
                    ch_err_d[cur_ch_q]  = 1'b1;
                end else if (eng_xfer_done) begin
                    state_d             = ARB_RESP;
                    ch_done_d[cur_ch_q] = 1'b1;
                end
`ifdef DMA_ARB_WDOG_EN
                else if (wdog_cnt_q == WDOG_LAST) begin
                    state_d             = ARB_RESP;
                    ch_done_d[cur_ch_q] = 1'b1;
                    ch_err_d[cur_ch_q]  = 1'b1;
                    wdog_trip_d         = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
                end
`endif
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        eng_valid_d = (state_d == ARB_ISSUE);
        idle_d      = (state_d == ARB_IDLE);
    end

    // State and registered outputs; reset abandons any in-flight transfer silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            cur_ch_q    <= '0;
            desc_q      <= '0;
            ch_done_q   <= '0;
            ch_err_q    <= '0;
            eng_valid_q <= 1'b0;
            idle_q      <= 1'b1;
            wdog_trip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_ch_q    <= cur_ch_d;
            desc_q      <= desc_d;
            ch_done_q   <= ch_done_d;
            ch_err_q    <= ch_err_d;
            eng_valid_q <= eng_valid_d;
            idle_q      <= idle_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

`ifdef DMA_ARB_WDOG_EN
    // Per-transfer WAIT cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`endif

    assign ch_done        = ch_done_q;
    assign ch_err         = ch_err_q;
    assign eng_desc_valid = eng_valid_q;
    assign eng_desc       = desc_q;
    assign arb_idle       = idle_q;
    assign cur_ch         = cur_ch_q;
    assign wdog_trip      = wdog_trip_q;

endmodule

// File: tb/tb_dma_desc_arbiter.sv
// Self-checking bench for dma_desc_arbiter: directed vector table, random transactions
// against a transaction-level round-robin model, reset and watchdog sequences.
module tb_dma_desc_arbiter;
    import dma_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WDOG   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en, ch_valid, ch_ready, ch_done, ch_err;
    dma_desc_t         ch_desc [NUM_CH];
    logic              eng_desc_valid, eng_desc_ready, eng_xfer_done, eng_xfer_error;
    dma_desc_t         eng_desc;
    logic              arb_idle, wdog_trip;
    logic [1:0]        cur_ch;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_ptr = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] en;
        bit         zero;
        int         rdy_dly;
        int         done_dly;
        int         mode;      // 0 done, 1 error, 2 both
        int         exp_ch;
        bit         exp_err;
    } vec_t;

    vec_t tbl [12];

    dma_desc_arbiter #(.NUM_CH(NUM_CH), .WDOG_CYCLES(WDOG)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch_en          (ch_en),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .ch_desc        (ch_desc),
        .ch_done        (ch_done),
        .ch_err         (ch_err),
        .eng_desc_valid (eng_desc_valid),
        .eng_desc_ready (eng_desc_ready),
        .eng_desc       (eng_desc),
        .eng_xfer_done  (eng_xfer_done),
        .eng_xfer_error (eng_xfer_error),
        .arb_idle       (arb_idle),
        .cur_ch         (cur_ch),
        .wdog_trip      (wdog_trip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_descs(input bit zero);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_desc[i].src_addr  = {$urandom, $urandom};
            ch_desc[i].dst_addr  = {$urandom, $urandom};
            ch_desc[i].bytes     = zero ? 32'd0 : 32'($urandom_range(1, 4096));
            ch_desc[i].xfer_type = 2'($urandom_range(0, 3));
        end
    endtask

    // Reference: first requester at or above the pointer, wrapping.
    function automatic int model_pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < NUM_CH; k++) begin
            if (req[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    // One complete transaction from grant to completion, checked along the way.
    task automatic txn(input logic [3:0] valid, input logic [3:0] en, input bit zero,
                       input int rdy_dly, input int done_dly, input int mode,
                       input int exp_ch, input bit exp_err);
        dma_desc_t  exp_d;
        logic [3:0] ch_bit;
        bit         bad;
        ch_bit = 4'(1 << exp_ch);
        chk("idle_before_grant", 256'(arb_idle), 256'(1));
        rand_descs(zero);
        ch_valid = valid;
        ch_en    = en;
        #1;
        chk("ch_ready_grant", 256'(ch_ready), 256'(ch_bit));
        exp_d = ch_desc[exp_ch];
        tick();
        ch_valid = '0;
        rand_descs(1'b0);
        model_ptr = (exp_ch + 1) % NUM_CH;
        if (zero) begin
            chk("zero_done", 256'(ch_done), 256'(ch_bit));
            chk("zero_err", 256'(ch_err), 256'(0));
            chk("zero_no_valid", 256'(eng_desc_valid), 256'(0));
            tick();
            chk("zero_done_clear", 256'(ch_done), 256'(0));
            chk("zero_idle_after", 256'(arb_idle), 256'(1));
            return;
        end
        chk("eng_valid_1cyc", 256'(eng_desc_valid), 256'(1));
        chk("eng_desc_captured", 256'(eng_desc), 256'(exp_d));
        bad = 1'b0;
        for (int k = 0; k < rdy_dly; k++) begin
            eng_xfer_done = (k == 0);
            tick();
            eng_xfer_done = 1'b0;
            if (eng_desc_valid !== 1'b1 || eng_desc !== exp_d || ch_done !== '0) bad = 1'b1;
        end
        if (rdy_dly > 0) chk("issue_hold_stable", 256'(bad), 256'(0));
        eng_desc_ready = 1'b1;
        tick();
        eng_desc_ready = 1'b0;
        chk("wait_valid_low", 256'(eng_desc_valid), 256'(0));
        chk("cur_ch", 256'(cur_ch), 256'(exp_ch));
        bad = 1'b0;
        for (int k = 0; k < done_dly; k++) begin
            tick();
            if (ch_done !== '0 || arb_idle !== 1'b0) bad = 1'b1;
        end
        chk("wait_no_early_done", 256'(bad), 256'(0));
        eng_xfer_done  = (mode != 1);
        eng_xfer_error = (mode != 0);
        tick();
        eng_xfer_done  = 1'b0;
        eng_xfer_error = 1'b0;
        chk("resp_done", 256'(ch_done), 256'(ch_bit));
        chk("resp_err", 256'(ch_err), 256'(exp_err ? ch_bit : 4'b0));
        tick();
        chk("resp_done_clear", 256'(ch_done), 256'(0));
        chk("idle_after_resp", 256'(arb_idle), 256'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] v, e;
        int         w, cycles;
        bit         got, bad;

        tbl[0]  = '{4'b1111, 4'b1111, 0, 0, 4, 0, 0, 0};
        tbl[1]  = '{4'b1111, 4'b1111, 0, 0, 4, 0, 1, 0};
        tbl[2]  = '{4'b1111, 4'b1111, 0, 0, 4, 0, 2, 0};
        tbl[3]  = '{4'b1111, 4'b1111, 0, 0, 4, 0, 3, 0};
        tbl[4]  = '{4'b1111, 4'b1111, 0, 0, 4, 0, 0, 0};
        tbl[5]  = '{4'b0001, 4'b1111, 0, 10, 2, 0, 0, 0};
        tbl[6]  = '{4'b1111, 4'b1010, 0, 1, 0, 0, 1, 0};
        tbl[7]  = '{4'b1111, 4'b1010, 0, 0, 3, 1, 3, 1};
        tbl[8]  = '{4'b0110, 4'b1111, 0, 2, 1, 0, 1, 0};
        tbl[9]  = '{4'b1100, 4'b0111, 1, 0, 0, 0, 2, 0};
        tbl[10] = '{4'b1001, 4'b1111, 0, 0, 2, 2, 3, 1};
        tbl[11] = '{4'b1111, 4'b1111, 0, 0, 0, 1, 0, 1};

        rst_n = 1'b0;
        ch_en = '0; ch_valid = '0;
        eng_desc_ready = 1'b0; eng_xfer_done = 1'b0; eng_xfer_error = 1'b0;
        rand_descs(1'b0);
        tick(); tick();
        chk("rst_idle", 256'(arb_idle), 256'(1));
        chk("rst_eng_valid", 256'(eng_desc_valid), 256'(0));
        chk("rst_eng_desc", 256'(eng_desc), 256'(0));
        chk("rst_outputs", 256'({ch_done, ch_err, cur_ch, wdog_trip, ch_ready}), 256'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].valid, tbl[i].en, tbl[i].zero, tbl[i].rdy_dly, tbl[i].done_dly,
                tbl[i].mode, tbl[i].exp_ch, tbl[i].exp_err);
        end

        for (int i = 0; i < 40; i++) begin
            do begin
                v = 4'($urandom);
                e = 4'($urandom);
            end while ((v & e) == 4'b0);
            w = model_pick(v & e, model_ptr);
            begin
                int mode;
                mode = $urandom_range(0, 2);
                txn(v, e, ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 6), mode, w, (mode != 0));
            end
        end

        // Reset while a transfer is in WAIT: silently abandoned, pointer back to 0.
        ch_valid = 4'b0100; ch_en = 4'b1111;
        tick();
        ch_valid = '0;
        eng_desc_ready = 1'b1;
        tick();
        eng_desc_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_idle", 256'(arb_idle), 256'(1));
        chk("midrst_outputs", 256'({eng_desc_valid, ch_done, ch_err, cur_ch, wdog_trip}), 256'(0));
        chk("midrst_eng_desc", 256'(eng_desc), 256'(0));
        rst_n = 1'b1;
        eng_xfer_done = 1'b1;
        tick();
        eng_xfer_done = 1'b0;
        tick();
        chk("midrst_no_done", 256'(ch_done), 256'(0));
        model_ptr = 0;
        txn(4'b1111, 4'b1111, 0, 0, 1, 0, 0, 0);

        // Silent engine: watchdog fires after WDOG wait cycles, or waits forever without it.
        ch_valid = 4'b0010;
        tick();
        ch_valid = '0;
        eng_desc_ready = 1'b1;
        tick();
        eng_desc_ready = 1'b0;
`ifdef DMA_ARB_WDOG_EN
        cycles = 0; got = 1'b0;
        while (cycles < 100 && !got) begin
            tick();
            cycles++;
            if (wdog_trip === 1'b1) got = 1'b1;
        end
        chk("wdog_trip_cycles", 256'(cycles), 256'(WDOG));
        chk("wdog_done", 256'(ch_done), 256'(4'b0010));
        chk("wdog_err", 256'(ch_err), 256'(4'b0010));
        tick();
        chk("wdog_trip_pulse", 256'(wdog_trip), 256'(0));
        eng_xfer_done = 1'b1;
        tick();
        eng_xfer_done = 1'b0;
        chk("wdog_late_done_ignored", 256'(ch_done), 256'(0));
        chk("wdog_idle", 256'(arb_idle), 256'(1));
`else
        bad = 1'b0;
        for (int k = 0; k < 3 * WDOG; k++) begin
            tick();
            if (wdog_trip !== 1'b0 || ch_done !== '0) bad = 1'b1;
        end
        chk("nowdog_waits", 256'({bad, arb_idle}), 256'(0));
        eng_xfer_done = 1'b1;
        tick();
        eng_xfer_done = 1'b0;
        chk("nowdog_done", 256'({ch_done, ch_err}), 256'({4'b0010, 4'b0000}));
        tick();
        chk("nowdog_idle", 256'(arb_idle), 256'(1));
`endif
        model_ptr = 2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
